median_out_collector: RTL

//  Downstream stage of the median cell array. Samples the shared R_median bus one cycle after each

---
 rtl/median_out_collector.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/median_out_collector.sv
// ---------------------------------------------------------------------------
// median_out_collector
//
// Downstream stage of the median cell array. One cycle after each accepted
// sample the shared R_median bus holds the new median. Medians are captured
// only once the window has filled. Captured medians go into a small circular
// FIFO, and the FIFO drains over a valid/ready stream. stall warns the sample
// sequencer early enough that every sample it sends while stall is low still
// finds room in the FIFO.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   W            in   active window size (0 is treated as 1); only changed
//                     while reset or clear is high
//   clear        in   synchronous restart, same effect as reset
//   sample_valid in   a new sample enters the cell array on this edge
//   R_median     in   shared median bus from the cells
//   stall        out  upstream must hold sample_valid low while high
//   m_data       out  FIFO head (zero while empty)
//   m_valid      out  m_data is valid
//   m_ready      in   consumer takes m_data when m_valid & m_ready
//   overflow     out  sticky: a median was dropped on a full FIFO
// ---------------------------------------------------------------------------
module median_out_collector #(
    parameter int DATA_LENGTH = 8,
    parameter int LOG_WMAX    = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LOG_WMAX-1:0]    W,
    input  logic                   clear,
    input  logic                   sample_valid,
    input  logic [DATA_LENGTH-1:0] R_median,
    output logic                   stall,
    output logic [DATA_LENGTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [DATA_LENGTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_LENGTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [LOG_WMAX-1:0]    fill_cnt_q, fill_cnt_d;
    logic                   cap_pend_q, cap_pend_d;
    logic                   overflow_q, overflow_d;

    logic [LOG_WMAX-1:0]    weff;
    logic                   window_full_next;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    // Next-state logic for warm-up, the capture pipeline and the FIFO.
    // A pending capture lands in the FIFO if there is room or if a pop in the
    // same cycle frees a slot; otherwise the median is dropped and the sticky
    // overflow flag records it. clear returns everything to the reset state
    // and overrides any activity in the same cycle.
    always_comb begin
        weff             = (W == '0) ? LOG_WMAX'(1) : W;
        window_full_next = (fill_cnt_q >= (weff - LOG_WMAX'(1)));
        fifo_full        = (count_q == CNT_W'(FIFO_DEPTH));
        pop              = (count_q != '0) && m_ready;
        push             = cap_pend_q && (!fifo_full || pop);

        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fill_cnt_d = fill_cnt_q;
        cap_pend_d = sample_valid && window_full_next;
        overflow_d = overflow_q;

        if (sample_valid && (fill_cnt_q < weff)) begin
            fill_cnt_d = fill_cnt_q + LOG_WMAX'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = R_median;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (cap_pend_q && !push) begin
            overflow_d = 1'b1;
        end

        if (clear) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fill_cnt_d = '0;
            cap_pend_d = 1'b0;
            overflow_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fill_cnt_q <= '0;
            cap_pend_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fill_cnt_q <= fill_cnt_d;
            cap_pend_q <= cap_pend_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs come from registers only. stall counts the in-flight capture
    // as already occupying a slot, so a sample accepted now still has room
    // when its median is pushed one cycle after the capture.
    always_comb begin
        m_valid  = (count_q != '0);
        m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
        overflow = overflow_q;
        stall    = ((SUM_W'(count_q) + SUM_W'(cap_pend_q)) >= SUM_W'(FIFO_DEPTH - 1));
    end

endmodule
